// File: rtl/rx_image_loader.sv
// rx_image_loader: pulls a framed pixel stream off a UART receiver and writes
// it into a pixel memory. Frame = SYNC_BYTE, length hi, length lo, N pixels.
// A watchdog aborts the frame if the byte stream stalls for TIMEOUT_CYC clocks.
module rx_image_loader #(
    parameter int          ADDR_W      = 16,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          TIMEOUT_CYC = 50_000_000
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              arm,
    input  logic              rx_ready,
    input  logic [7:0]        rx_data,
    output logic              rx_ready_clr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] pix_count
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LEN_HI,
        LEN_LO,
        LOAD
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              accept;
    logic              timing;
    logic              timed_out;
    logic              last_pix;
    logic [7:0]        len_hi;
    logic [ADDR_W-1:0] len_n;
    logic [ADDR_W-1:0] addr_cnt;
    logic [TMR_W-1:0]  timer;

    // The receiver drops rx_ready one cycle after our ack, so the ack cycle
    // itself must never consume a byte.
    assign accept    = rx_ready && !rx_ready_clr && (state != IDLE);
    assign timing    = (state == LEN_HI) || (state == LEN_LO) || (state == LOAD);
    assign timed_out = timing && !accept && (timer == TMR_W'(TIMEOUT_CYC));
    // Header length is 16 bits; the cast truncates or zero-extends to ADDR_W.
    assign len_n     = ADDR_W'({len_hi, rx_data});
    assign last_pix  = (addr_cnt == pix_count - ADDR_W'(1));
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk_50m) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: byte-driven frame parsing with watchdog abort.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (arm) state_nxt = SYNC;
            SYNC:    if (accept && rx_data == SYNC_BYTE) state_nxt = LEN_HI;
            LEN_HI:  if (accept) state_nxt = LEN_LO;
            LEN_LO:  if (accept) state_nxt = (len_n == '0) ? IDLE : LOAD;
            LOAD:    if (accept && last_pix) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (timed_out) state_nxt = IDLE;
    end

    // Byte handshake, header capture, pixel writes and status flags.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            rx_ready_clr <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            pix_count    <= '0;
            len_hi       <= '0;
            addr_cnt     <= '0;
        end else begin
            rx_ready_clr <= accept;
            mem_we       <= accept && (state == LOAD);
            done         <= accept && (((state == LEN_LO) && (len_n == '0)) ||
                                       ((state == LOAD) && last_pix));

            if (state == IDLE && arm) err <= 1'b0;
            else if (timed_out)       err <= 1'b1;

            if (accept && state == LEN_HI) len_hi <= rx_data;

            if (accept && state == LEN_LO) begin
                pix_count <= len_n;
                addr_cnt  <= '0;
            end

            if (accept && state == LOAD) begin
                mem_addr  <= addr_cnt;
                mem_wdata <= rx_data;
                addr_cnt  <= addr_cnt + ADDR_W'(1);
            end
        end
    end

    // Inter-byte watchdog: runs only while a frame header or payload is pending.
    always_ff @(posedge clk_50m) begin
        if (rst)                                 timer <= '0;
        else if (accept || !timing || timed_out) timer <= '0;
        else                                     timer <= timer + TMR_W'(1);
    end

endmodule
